// File: rtl/matmul_pkg.sv
// Shared element types and width helpers for the matmul datapath.
// The typedefs describe the default 8-bit operand configuration; modules
// that take a width parameter derive their own widths with accWidth().
package matmul_pkg;

    localparam int DEFAULT_P = 8;

    // Accumulator and result elements are four times the operand width, which
    // leaves headroom for the 2P-bit products plus a wide external accumulator.
    function automatic int accWidth(input int p);
        return 4 * p;
    endfunction

    localparam int DEFAULT_ACC_W = accWidth(DEFAULT_P);

    typedef logic signed [DEFAULT_P-1:0]     operand_t;
    typedef logic signed [DEFAULT_ACC_W-1:0] acc_t;

endpackage

// File: rtl/mac_dot_product.sv
// One output element of the matrix engine: a K-term signed dot product
// added onto an accumulator value, purely combinational.
module mac_dot_product
    import matmul_pkg::*;
#(
    parameter int K = 2,
    parameter int P = 8
) (
    input  logic [K-1:0][P-1:0]     a_i,
    input  logic [K-1:0][P-1:0]     b_i,
    input  logic [accWidth(P)-1:0]  c_i,
    output logic [accWidth(P)-1:0]  sum_o
);

    localparam int AW = accWidth(P);

    logic signed [2*P-1:0] products [K];
    logic signed [AW-1:0]  total;

    // Form every full-precision signed product; the 2P-bit target keeps the
    // -2^(P-1) * -2^(P-1) corner case exact.
    always_comb begin
        for (int k = 0; k < K; k++) begin
            products[k] = $signed(a_i[k]) * $signed(b_i[k]);
        end
    end

    // Sum the sign-extended products onto the accumulator. Two's-complement
    // addition modulo 2^AW gives exactly the low AW bits of the unbounded sum,
    // so carrying the wider intermediate would only produce bits we discard.
    always_comb begin
        total = $signed(c_i);
        for (int k = 0; k < K; k++) begin
            total = total + AW'(products[k]);
        end
    end

    assign sum_o = total;

endmodule

// File: rtl/matrix_multiply_accumulate.sv
// Signed matrix multiply-accumulate, D = A*B + C, with a single registered
// output stage. One dot-product unit per output element feeds the register.
module matrix_multiply_accumulate
    import matmul_pkg::*;
#(
    parameter int M = 2,
    parameter int N = 2,
    parameter int K = 2,
    parameter int P = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 in_valid_i,
    input  logic [M-1:0][K-1:0][P-1:0]           a_i,
    input  logic [K-1:0][N-1:0][P-1:0]           b_i,
    input  logic [M-1:0][N-1:0][accWidth(P)-1:0] c_i,
    output logic                                 out_valid_o,
    output logic [M-1:0][N-1:0][accWidth(P)-1:0] d_o
);

    localparam int AW = accWidth(P);

    logic [M-1:0][N-1:0][AW-1:0] sumAll;
    logic [M-1:0][N-1:0][AW-1:0] result_d;
    logic [M-1:0][N-1:0][AW-1:0] result_q;
    logic                        valid_d;
    logic                        valid_q;

    for (genvar gi = 0; gi < M; gi++) begin : gRow
        for (genvar gj = 0; gj < N; gj++) begin : gCol
            logic [K-1:0][P-1:0] colB;

            // Gather column gj of B so each unit sees matching operand pairs.
            always_comb begin
                for (int k = 0; k < K; k++) begin
                    colB[k] = b_i[k][gj];
                end
            end

            mac_dot_product #(
                .K (K),
                .P (P)
            ) uDot (
                .a_i   (a_i[gi]),
                .b_i   (colB),
                .c_i   (c_i[gi][gj]),
                .sum_o (sumAll[gi][gj])
            );
        end
    end

    // Capture a fresh result only on accepted input; otherwise the old
    // matrix is held and the valid flag drops for that cycle.
    always_comb begin
        result_d = result_q;
        valid_d  = 1'b0;
        if (in_valid_i) begin
            result_d = sumAll;
            valid_d  = 1'b1;
        end
    end

    // Output register; reset wins over a simultaneous input, discarding it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign d_o         = result_q;
    assign out_valid_o = valid_q;

endmodule

// File: tb/tb_matrix_multiply_accumulate.sv
// Directed bench for the 2x2x2, 8-bit configuration: stimulus pushes
// hand-computed results into a queue, a monitor pops them as outputs appear.
module tb_matrix_multiply_accumulate;
    import matmul_pkg::*;

    typedef logic [1:0][1:0][7:0]  opMat_t;
    typedef logic [1:0][1:0][31:0] accMat_t;

    logic    clk;
    logic    rst;
    logic    inValid;
    opMat_t  aIn;
    opMat_t  bIn;
    accMat_t cIn;
    logic    outValid;
    accMat_t dOut;

    accMat_t expQ[$];
    accMat_t lastD;
    int      checks;
    int      fails;

    matrix_multiply_accumulate #(
        .M (2),
        .N (2),
        .K (2),
        .P (8)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (inValid),
        .a_i         (aIn),
        .b_i         (bIn),
        .c_i         (cIn),
        .out_valid_o (outValid),
        .d_o         (dOut)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic opMat_t mk8(input int e00, input int e01, input int e10, input int e11);
        opMat_t m;
        m[0][0] = 8'(e00);
        m[0][1] = 8'(e01);
        m[1][0] = 8'(e10);
        m[1][1] = 8'(e11);
        return m;
    endfunction

    function automatic accMat_t mk32(input acc_t e00, input acc_t e01, input acc_t e10, input acc_t e11);
        accMat_t m;
        m[0][0] = e00;
        m[0][1] = e01;
        m[1][0] = e10;
        m[1][1] = e11;
        return m;
    endfunction

    // Drive one cycle of inputs at the falling edge; accepted inputs queue
    // their expected result for the monitor.
    task automatic applyStimulus(input opMat_t a, input opMat_t b, input accMat_t c,
                                 input logic valid, input logic doReset, input accMat_t expected);
        @(negedge clk);
        aIn     = a;
        bIn     = b;
        cIn     = c;
        inValid = valid;
        rst     = doReset;
        if (valid && !doReset) begin
            expQ.push_back(expected);
            lastD = expected;
        end
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] required);
        checks++;
        if (actual !== required) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, required);
        end
    endtask

    // Monitor: every presented result must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (outValid === 1'b1) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_out_valid", {127'b0, outValid}, 128'b0);
                end else begin
                    checkOutput("result", dOut, expQ.pop_front());
                end
            end
        end
    end

    initial begin
        accMat_t zero;
        opMat_t  negA;
        zero    = '0;
        negA    = mk8(-128, -128, -128, -128);
        checks  = 0;
        fails   = 0;
        lastD   = '0;
        rst     = 1'b1;
        inValid = 1'b0;
        aIn     = '0;
        bIn     = '0;
        cIn     = '0;

        // Reset with garbage on the inputs.
        applyStimulus(mk8(9, 9, 9, 9), mk8(9, 9, 9, 9), zero, 1'b1, 1'b1, zero);
        applyStimulus(mk8(9, 9, 9, 9), mk8(9, 9, 9, 9), zero, 1'b0, 1'b1, zero);
        @(posedge clk); #1;
        checkOutput("reset_out_valid", {127'b0, outValid}, 128'b0);
        checkOutput("reset_d", dOut, 128'b0);

        // Back-to-back accepted inputs.
        applyStimulus(mk8(1, 2, 3, 4), mk8(5, 6, 7, 8), zero, 1'b1, 1'b0,
                      mk32(19, 22, 43, 50));
        applyStimulus(mk8(-1, 2, 3, -4), mk8(5, -6, 7, 8), mk32(100, -100, 0, 1), 1'b1, 1'b0,
                      mk32(109, -78, -13, -49));
        applyStimulus(negA, negA, zero, 1'b1, 1'b0,
                      mk32(32768, 32768, 32768, 32768));
        applyStimulus(negA, negA, mk32(2147450879, 2147450879, 2147450879, 2147450879), 1'b1, 1'b0,
                      mk32(2147483647, 2147483647, 2147483647, 2147483647));
        applyStimulus(mk8(1, 0, 0, 0), mk8(1, 0, 0, 0), mk32(2147483647, 5, -7, 9), 1'b1, 1'b0,
                      mk32(-2147483647 - 1, 5, -7, 9));

        // Idle cycle: flag drops, result held.
        applyStimulus(mk8(3, 3, 3, 3), mk8(3, 3, 3, 3), zero, 1'b0, 1'b0, zero);
        @(posedge clk); #1;
        checkOutput("hold_out_valid", {127'b0, outValid}, 128'b0);
        checkOutput("hold_d", dOut, lastD);

        // Reset coinciding with a valid input discards that input.
        applyStimulus(mk8(1, 2, 3, 4), mk8(5, 6, 7, 8), zero, 1'b1, 1'b1, zero);
        @(posedge clk); #1;
        checkOutput("rst_prio_out_valid", {127'b0, outValid}, 128'b0);
        checkOutput("rst_prio_d", dOut, 128'b0);

        // First cycle after reset accepts normally.
        applyStimulus(mk8(1, 2, 3, 4), mk8(5, 6, 7, 8), zero, 1'b1, 1'b0,
                      mk32(19, 22, 43, 50));
        applyStimulus(zero[0], zero[0], zero, 1'b0, 1'b0, zero);

        // Bounded drain so the monitor can consume the last result.
        for (int i = 0; i < 4; i++) @(posedge clk);
        #1;
        checkOutput("queue_drained", 128'(expQ.size()), 128'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
